// File: rtl/mux_rr_n.sv
// N-input registered multiplexer with valid/ready handshake.
// Selection is either a fixed external select or round-robin starting at ptr.
module mux_rr_n #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS*WIDTH-1:0]    in_data,
    input  logic [CHANNELS-1:0]          in_valid,
    output logic [CHANNELS-1:0]          in_ready,
    input  logic                         mode,
    input  logic [SEL_W-1:0]             s,
    output logic [WIDTH-1:0]             out_data,
    output logic [SEL_W-1:0]             out_chan,
    output logic                         out_valid,
    input  logic                         out_ready
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_vld;
    logic             load;
    logic [SEL_W:0]   rr_sum;
    logic [WIDTH-1:0] sel_data;

    assign load = !out_valid || out_ready;

    // Round-robin search runs from the highest offset down so the channel
    // nearest ptr is the last (winning) assignment.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        rr_sum    = '0;
        if (!mode) begin
            if (({1'b0, s} < (SEL_W+1)'(CHANNELS)) && in_valid[s]) begin
                grant_vld = 1'b1;
                grant_idx = s;
            end
        end else begin
            for (int k = CHANNELS - 1; k >= 0; k--) begin
                rr_sum = {1'b0, ptr} + (SEL_W+1)'(k);
                if (rr_sum >= (SEL_W+1)'(CHANNELS))
                    rr_sum = rr_sum - (SEL_W+1)'(CHANNELS);
                if (in_valid[rr_sum[SEL_W-1:0]]) begin
                    grant_vld = 1'b1;
                    grant_idx = rr_sum[SEL_W-1:0];
                end
            end
        end
    end

    always_comb begin
        sel_data = '0;
        in_ready = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (grant_idx == SEL_W'(c))
                sel_data = in_data[c*WIDTH +: WIDTH];
            // Gated by reset so nothing is acknowledged while held in reset.
            in_ready[c] = reset && load && grant_vld && (grant_idx == SEL_W'(c));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= '0;
        end else if (load && grant_vld) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_chan  <= grant_idx;
            if (mode) begin
                if (grant_idx == SEL_W'(CHANNELS - 1))
                    ptr <= '0;
                else
                    ptr <= grant_idx + 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_rr_n.sv
// Self-checking bench for mux_rr_n: directed scenarios plus randomized traffic
// compared against a transaction-level model of the selection rules.
module tb_mux_rr_n;

    localparam int W = 4;
    localparam int N = 4;
    localparam int SW = 2;

    logic          clk;
    logic          reset;
    logic [N*W-1:0] in_data;
    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_ready;
    logic          mode;
    logic [SW-1:0] s;
    logic [W-1:0]  out_data;
    logic [SW-1:0] out_chan;
    logic          out_valid;
    logic          out_ready;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: held word and arbitration pointer.
    bit       m_valid;
    logic [W-1:0]  m_data;
    logic [SW-1:0] m_chan;
    int       m_ptr;

    mux_rr_n #(.WIDTH(W), .CHANNELS(N), .SEL_W(SW)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .s(s), .out_data(out_data),
        .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int exp_grant();
        if (!mode) return in_valid[s] ? int'(s) : -1;
        for (int k = 0; k < N; k++)
            if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        g = exp_grant();
        if (g < 0 || !(!m_valid || out_ready)) return '0;
        return N'(1) << g;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_data = '0; m_chan = '0; m_ptr = 0;
    endtask

    // Advance one clock and apply the transfer rules to the model.
    task automatic tick();
        int g;
        bit ld;
        g  = exp_grant();
        ld = !m_valid || out_ready;
        @(posedge clk);
        if (ld && g >= 0) begin
            m_valid = 1;
            m_data  = in_data[g*W +: W];
            m_chan  = SW'(g);
            if (mode) m_ptr = (g + 1) % N;
        end else if (out_ready) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; mode = 0; s = 0; in_valid = '0; in_data = '0; out_ready = 0;
        model_reset();
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== 4'h0) $display("FAIL reset_data got %h want 0", out_data); else n_pass++;
        n_checks++; if (out_chan !== 2'd0) $display("FAIL reset_chan got %0d want 0", out_chan); else n_pass++;
        reset = 1'b1;
        // Load a word and hold it under backpressure, then reset between edges.
        in_data = 16'h3219; in_valid = 4'b1111; s = 2'd0;
        tick();
        n_checks++; if (out_valid !== 1'b1) $display("FAIL pre_reset_valid got %b want 1", out_valid); else n_pass++;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL async_reset_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== 4'h0) $display("FAIL async_reset_data got %h want 0", out_data); else n_pass++;
        n_checks++; if (in_ready !== 4'b0000) $display("FAIL async_reset_ready got %b want 0000", in_ready); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_fixed();
        mode = 0; s = 2'd1; in_data = 16'h3210; in_valid = 4'b1111; out_ready = 1;
        #1;
        n_checks++; if (in_ready !== 4'b0010) $display("FAIL fixed_ready got %b want 0010", in_ready); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 4'h1 || out_chan !== 2'd1)
            $display("FAIL fixed_s1 got v=%b d=%h c=%0d want v=1 d=1 c=1", out_valid, out_data, out_chan); else n_pass++;
        s = 2'd0;
        #1;
        n_checks++; if (in_ready !== 4'b0001) $display("FAIL fixed_ready_s0 got %b want 0001", in_ready); else n_pass++;
        tick();
        n_checks++; if (out_data !== 4'h0 || out_chan !== 2'd0)
            $display("FAIL fixed_s0 got d=%h c=%0d want d=0 c=0", out_data, out_chan); else n_pass++;
    endtask

    task automatic test_fixed_idle();
        mode = 0; s = 2'd2; in_valid = 4'b0011; out_ready = 1;
        #1;
        n_checks++; if (in_ready !== 4'b0000) $display("FAIL idle_ready got %b want 0000", in_ready); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL idle_drain got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== 4'h0 || out_chan !== 2'd0)
            $display("FAIL idle_keep got d=%h c=%0d want d=0 c=0", out_data, out_chan); else n_pass++;
    endtask

    task automatic test_round_robin();
        int seq[5] = '{0, 1, 2, 3, 0};
        mode = 1; in_valid = 4'b1111; in_data = 16'hA987; out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (in_ready !== (4'b0001 << seq[i]))
                $display("FAIL rr_ready[%0d] got %b want one-hot %0d", i, in_ready, seq[i]); else n_pass++;
            tick();
            n_checks++; if (out_valid !== 1'b1 || out_chan !== 2'(seq[i]) || out_data !== in_data[seq[i]*W +: W])
                $display("FAIL rr_chan[%0d] got v=%b c=%0d d=%h want c=%0d", i, out_valid, out_chan, out_data, seq[i]); else n_pass++;
        end
    endtask

    task automatic test_skip_wrap();
        int seq[3] = '{0, 2, 0};
        mode = 1; out_ready = 1; in_valid = 4'b0100;
        tick();
        n_checks++; if (out_chan !== 2'd2) $display("FAIL skip_setup got %0d want 2", out_chan); else n_pass++;
        in_valid = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (out_chan !== 2'(seq[i]))
                $display("FAIL skip_wrap[%0d] got %0d want %0d", i, out_chan, seq[i]); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0]  held_d;
        logic [SW-1:0] held_c;
        int g;
        mode = 1; in_valid = 4'b1111; out_ready = 1;
        tick();
        held_d = out_data; held_c = out_chan;
        n_checks++; if (out_data !== m_data || out_chan !== m_chan)
            $display("FAIL bp_load got d=%h c=%0d want d=%h c=%0d", out_data, out_chan, m_data, m_chan); else n_pass++;
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            in_data = 16'($urandom);
            #1;
            n_checks++; if (in_ready !== 4'b0000) $display("FAIL bp_ready[%0d] got %b want 0000", i, in_ready); else n_pass++;
            tick();
            n_checks++; if (out_valid !== 1'b1 || out_data !== held_d || out_chan !== held_c)
                $display("FAIL bp_hold[%0d] got v=%b d=%h c=%0d want v=1 d=%h c=%0d", i, out_valid, out_data, out_chan, held_d, held_c); else n_pass++;
        end
        out_ready = 1;
        g = (int'(held_c) + 1) % N;
        #1;
        n_checks++; if (in_ready !== (4'b0001 << g)) $display("FAIL bp_release_ready got %b want one-hot %0d", in_ready, g); else n_pass++;
        tick();
        n_checks++; if (out_chan !== 2'(g) || out_data !== in_data[g*W +: W])
            $display("FAIL bp_release got c=%0d d=%h want c=%0d d=%h", out_chan, out_data, g, in_data[g*W +: W]); else n_pass++;
    endtask

    task automatic test_random();
        logic [N-1:0] er;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) mode = 1'($urandom);
            s         = 2'($urandom);
            in_valid  = 4'($urandom);
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            er = exp_ready();
            n_checks++; if (in_ready !== er) $display("FAIL rand_ready[%0d] got %b want %b", i, in_ready, er); else n_pass++;
            tick();
            n_checks++; if (out_valid !== m_valid || out_data !== m_data || out_chan !== m_chan)
                $display("FAIL rand_out[%0d] got v=%b d=%h c=%0d want v=%b d=%h c=%0d",
                         i, out_valid, out_data, out_chan, m_valid, m_data, m_chan); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_fixed_idle();
        test_round_robin();
        test_skip_wrap();
        test_backpressure();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
